tpm_host_arbiter: RTL



---
 rtl/tpm_arb_pkg.sv | 17 +
 rtl/tpm_arb_sync.sv | 25 ++
 rtl/tpm_host_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/tpm_arb_pkg.sv
// Shared types and helpers for the two-port TPM register-access arbiter.
package tpm_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } tpm_arb_state_e;

    localparam logic [7:0] TO_RDATA_DEFAULT = 8'hFF;

    // Timer only ever holds 0..timeout-1.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/tpm_arb_sync.sv
// Multi-flop single-bit synchroniser with asynchronous active-high reset.
module tpm_arb_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d_i};
        end
    end

    assign q_o = r_sync[STAGES-1];

endmodule

// File: rtl/tpm_host_arbiter.sv
// Shares one TPM register backend between two byte-access requesters, with per-frame
// locking, round-robin tie break and a backend ack timeout.
module tpm_host_arbiter
    import tpm_arb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter logic [7:0]  TO_RDATA    = TO_RDATA_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        r0_frame_i,
    input  logic [15:0] r0_addr_i,
    input  logic [7:0]  r0_wdata_i,
    input  logic        r0_data_wr_i,
    output logic        r0_wr_done_o,
    input  logic        r0_data_req_i,
    output logic        r0_data_rd_o,
    output logic [7:0]  r0_rdata_o,
    input  logic        r1_frame_i,
    input  logic [15:0] r1_addr_i,
    input  logic [7:0]  r1_wdata_i,
    input  logic        r1_data_wr_i,
    output logic        r1_wr_done_o,
    input  logic        r1_data_req_i,
    output logic        r1_data_rd_o,
    output logic [7:0]  r1_rdata_o,
    output logic [15:0] reg_addr_o,
    output logic [7:0]  reg_wdata_o,
    output logic        reg_we_o,
    output logic        reg_re_o,
    input  logic [7:0]  reg_rdata_i,
    input  logic        reg_ack_i,
    output logic        owner_o,
    output logic        timeout_o
);

    localparam int unsigned         TIMER_W    = timer_width(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic [1:0] w_frame_raw, w_wr_raw, w_rd_raw;
    logic [1:0] w_frame, w_wr, w_rd;

    assign w_frame_raw = {r1_frame_i, r0_frame_i};
    assign w_wr_raw    = {r1_data_wr_i, r0_data_wr_i};
    assign w_rd_raw    = {r1_data_req_i, r0_data_req_i};

    for (genvar gp = 0; gp < 2; gp++) begin : g_port
        tpm_arb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_frame (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (w_frame_raw[gp]),
            .q_o   (w_frame[gp])
        );
        tpm_arb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (w_wr_raw[gp]),
            .q_o   (w_wr[gp])
        );
        tpm_arb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .d_i   (w_rd_raw[gp]),
            .q_o   (w_rd[gp])
        );
    end

    tpm_arb_state_e     r_state, w_state_nxt;
    logic               r_owner, w_owner_nxt;
    logic               r_rr_last, w_rr_last_nxt;
    logic               r_lock, w_lock_nxt;
    logic               r_lock_port, w_lock_port_nxt;
    logic               r_dir_wr, w_dir_wr_nxt;
    logic [15:0]        r_addr, w_addr_nxt;
    logic [7:0]         r_wdata, w_wdata_nxt;
    logic [TIMER_W-1:0] r_timer, w_timer_nxt;
    logic [1:0]         r_wr_done, w_wr_done_nxt;
    logic [1:0]         r_data_rd, w_data_rd_nxt;
    logic [1:0][7:0]    r_rdata, w_rdata_nxt;
    logic               r_timeout, w_timeout_nxt;

    logic [1:0] w_req, w_eligible;
    logic       w_locked, w_grant_valid, w_winner, w_owner_req;

    // A port already holding its done output is not a new request.
    assign w_req         = (w_wr | w_rd) & ~(r_wr_done | r_data_rd);
    assign w_locked      = r_lock & w_frame[r_lock_port];
    assign w_eligible    = w_locked ? (w_req & (r_lock_port ? 2'b10 : 2'b01)) : w_req;
    assign w_grant_valid = |w_eligible;
    assign w_winner      = (&w_eligible) ? ~r_rr_last : w_eligible[1];
    assign w_owner_req   = r_dir_wr ? w_wr[r_owner] : w_rd[r_owner];

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_last_nxt   = r_rr_last;
        w_lock_nxt      = r_lock;
        w_lock_port_nxt = r_lock_port;
        w_dir_wr_nxt    = r_dir_wr;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_timer_nxt     = r_timer;
        w_wr_done_nxt   = r_wr_done;
        w_data_rd_nxt   = r_data_rd;
        w_rdata_nxt     = r_rdata;
        w_timeout_nxt   = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_lock_nxt = w_locked;
                if (w_grant_valid) begin
                    w_state_nxt     = StAccess;
                    w_owner_nxt     = w_winner;
                    w_rr_last_nxt   = w_winner;
                    w_lock_nxt      = w_frame[w_winner];
                    w_lock_port_nxt = w_winner;
                    // Write wins if a requester raises both strobes.
                    w_dir_wr_nxt    = w_wr[w_winner];
                    w_addr_nxt      = w_winner ? r1_addr_i : r0_addr_i;
                    w_wdata_nxt     = w_winner ? r1_wdata_i : r0_wdata_i;
                    w_timer_nxt     = '0;
                end
            end
            StAccess: begin
                if (reg_ack_i) begin
                    w_state_nxt = StDone;
                    if (!r_dir_wr) begin
                        w_rdata_nxt[r_owner] = reg_rdata_i;
                    end
                    w_wr_done_nxt[r_owner] = r_dir_wr;
                    w_data_rd_nxt[r_owner] = ~r_dir_wr;
                end else if (r_timer == TIMER_LAST) begin
                    w_state_nxt   = StDone;
                    w_timeout_nxt = 1'b1;
                    if (!r_dir_wr) begin
                        w_rdata_nxt[r_owner] = TO_RDATA;
                    end
                    w_wr_done_nxt[r_owner] = r_dir_wr;
                    w_data_rd_nxt[r_owner] = ~r_dir_wr;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            StDone: begin
                if (!w_owner_req) begin
                    w_state_nxt   = StIdle;
                    w_wr_done_nxt = '0;
                    w_data_rd_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_owner     <= 1'b0;
            r_rr_last   <= 1'b1;
            r_lock      <= 1'b0;
            r_lock_port <= 1'b0;
            r_dir_wr    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_timer     <= '0;
            r_wr_done   <= '0;
            r_data_rd   <= '0;
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_lock      <= w_lock_nxt;
            r_lock_port <= w_lock_port_nxt;
            r_dir_wr    <= w_dir_wr_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_timer     <= w_timer_nxt;
            r_wr_done   <= w_wr_done_nxt;
            r_data_rd   <= w_data_rd_nxt;
            r_rdata     <= w_rdata_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign reg_we_o     = (r_state == StAccess) & r_dir_wr;
    assign reg_re_o     = (r_state == StAccess) & ~r_dir_wr;
    assign reg_addr_o   = r_addr;
    assign reg_wdata_o  = r_wdata;
    assign owner_o      = r_owner;
    assign timeout_o    = r_timeout;
    assign r0_wr_done_o = r_wr_done[0];
    assign r1_wr_done_o = r_wr_done[1];
    assign r0_data_rd_o = r_data_rd[0];
    assign r1_data_rd_o = r_data_rd[1];
    assign r0_rdata_o   = r_rdata[0];
    assign r1_rdata_o   = r_rdata[1];

endmodule
